// File: rtl/sram_rw_sequencer.sv
// Timing controller for a 6T SRAM array: precharge, one-hot wordline, write drive, sense per access.
// Response PRE_CYC+ACT_CYC+2 cycles after acceptance (read) or +1 (write); req_ready is high only when idle.
module sram_rw_sequencer #(
  parameter int AW      = 4,
  parameter int ROWS    = 16,
  parameter int COLS    = 8,
  parameter int PRE_CYC = 2,
  parameter int ACT_CYC = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [AW-1:0]   req_addr,
  input  logic [COLS-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [COLS-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic [ROWS-1:0] wl,
  output logic            pre_n,
  output logic            bl_drv_en,
  output logic [COLS-1:0] bl_wdata,
  output logic            sae,
  input  logic [COLS-1:0] sa_data
);
  localparam int MAXC = (PRE_CYC > ACT_CYC) ? PRE_CYC : ACT_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {IDLE, PRE, ACT, SENSE, RECOV} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q, err_q;
  logic [ROWS-1:0] row_q, row_dec;
  logic [COLS-1:0] wdata_q;
  logic            accept;

  logic            req_ready_q, req_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [COLS-1:0] rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;
  logic [ROWS-1:0] wl_q, wl_d;
  logic            pre_n_q, pre_n_d;
  logic            bl_drv_en_q, bl_drv_en_d;
  logic [COLS-1:0] bl_wdata_q, bl_wdata_d;
  logic            sae_q, sae_d;

  assign accept = req_valid & req_ready_q;

  // Out-of-range addresses decode to an all-zero row, which doubles as the error flag.
  always_comb begin
    row_dec = '0;
    for (int r = 0; r < ROWS; r++) row_dec[r] = (req_addr == AW'(r));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (accept) begin
        state_d = PRE;
        cnt_d   = CW'(PRE_CYC - 1);
      end
      PRE: if (cnt_q == '0) begin
        state_d = ACT;
        cnt_d   = CW'(ACT_CYC - 1);
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      ACT: if (cnt_q == '0) begin
        state_d = we_q ? RECOV : SENSE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      SENSE: begin
        state_d = RECOV;
        cnt_d   = '0;
      end
      RECOV: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered pins line up with state_q.
  always_comb begin
    req_ready_d = (state_d == IDLE);
    pre_n_d     = (state_d != PRE);
    wl_d        = ((state_d == ACT) || (state_d == SENSE)) ? row_q : '0;
    bl_drv_en_d = (state_d == ACT) && we_q;
    bl_wdata_d  = ((state_d == ACT) && we_q) ? wdata_q : '0;
    sae_d       = (state_d == SENSE);
    rsp_valid_d = (state_d == RECOV);
    rsp_err_d   = (state_d == RECOV) && err_q;
    rsp_rdata_d = rsp_rdata_q;
    if (state_q == SENSE)       rsp_rdata_d = err_q ? '0 : sa_data;
    else if (state_d == RECOV)  rsp_rdata_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      row_q       <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      wl_q        <= '0;
      pre_n_q     <= 1'b1;
      bl_drv_en_q <= 1'b0;
      bl_wdata_q  <= '0;
      sae_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= req_we;
        row_q   <= row_dec;
        err_q   <= ~|row_dec;
        wdata_q <= req_wdata;
      end
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      wl_q        <= wl_d;
      pre_n_q     <= pre_n_d;
      bl_drv_en_q <= bl_drv_en_d;
      bl_wdata_q  <= bl_wdata_d;
      sae_q       <= sae_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign wl        = wl_q;
  assign pre_n     = pre_n_q;
  assign bl_drv_en = bl_drv_en_q;
  assign bl_wdata  = bl_wdata_q;
  assign sae       = sae_q;

  a_wl_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(wl_q));
  a_wl_pre:    assert property (@(posedge clk) disable iff (!rst_n) !((|wl_q) && !pre_n_q));
  a_drv_wr:    assert property (@(posedge clk) disable iff (!rst_n) bl_drv_en_q |-> (state_q == ACT && we_q));
  a_sae_rd:    assert property (@(posedge clk) disable iff (!rst_n) sae_q |-> (state_q == SENSE && !we_q));
  a_excl:      assert property (@(posedge clk) disable iff (!rst_n) !(sae_q && bl_drv_en_q));
  a_pulse:     assert property (@(posedge clk) disable iff (!rst_n) rsp_valid_q |=> !rsp_valid_q);
endmodule

// File: tb/tb_sram_rw_sequencer.sv
// Bench for sram_rw_sequencer: array model plus response scoreboard; a second instance uses ROWS=12.
module tb_sram_rw_sequencer;
  localparam int AW = 4, ROWS = 16, COLS = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [COLS-1:0] req_wdata = '0;
  logic rsp_valid, rsp_err, pre_n, bl_drv_en, sae;
  logic [COLS-1:0] rsp_rdata, bl_wdata, sa_data;
  logic [ROWS-1:0] wl;

  logic r2_valid = 1'b0, r2_ready, r2_we = 1'b0;
  logic [AW-1:0] r2_addr = '0;
  logic [COLS-1:0] r2_wdata = '0;
  logic p2_valid, p2_err, pre2_n, drv2, sae2;
  logic [COLS-1:0] p2_rdata, bl2_wdata, sa2_data;
  logic [11:0] wl2;

  sram_rw_sequencer #(.AW(AW), .ROWS(ROWS), .COLS(COLS), .PRE_CYC(2), .ACT_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .wl(wl), .pre_n(pre_n), .bl_drv_en(bl_drv_en), .bl_wdata(bl_wdata),
    .sae(sae), .sa_data(sa_data));

  sram_rw_sequencer #(.AW(AW), .ROWS(12), .COLS(COLS), .PRE_CYC(2), .ACT_CYC(2)) dut12 (
    .clk(clk), .rst_n(rst_n), .req_valid(r2_valid), .req_ready(r2_ready), .req_we(r2_we),
    .req_addr(r2_addr), .req_wdata(r2_wdata), .rsp_valid(p2_valid), .rsp_rdata(p2_rdata),
    .rsp_err(p2_err), .wl(wl2), .pre_n(pre2_n), .bl_drv_en(drv2), .bl_wdata(bl2_wdata),
    .sae(sae2), .sa_data(sa2_data));

  int n_cmp = 0, n_err = 0;

  typedef struct packed {logic err; logic [COLS-1:0] rdata;} rsp_t;
  rsp_t exp_q[$];
  rsp_t mon_e;
  logic prev_vld = 1'b0;

  logic [COLS-1:0] arr    [ROWS] = '{default: '0};
  logic [COLS-1:0] shadow [ROWS] = '{default: '0};

  // Array model: latch write data into the driven row; present junk unless sensing.
  always @(posedge clk)
    if (bl_drv_en)
      for (int r = 0; r < ROWS; r++) if (wl[r]) arr[r] <= bl_wdata;

  always_comb begin
    sa_data = 8'h3C;
    if (sae)
      for (int r = 0; r < ROWS; r++) if (wl[r]) sa_data = arr[r];
  end

  assign sa2_data = sae2 ? 8'hFF : 8'h00;

  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      n_cmp++;
      if (prev_vld) begin
        n_err++;
        $display("FAIL rsp_held: rsp_valid=1 for two cycles, required single pulse");
      end
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rsp_unexpected: got err=%b rdata=%h, required no response", rsp_err, rsp_rdata);
      end else begin
        mon_e = exp_q.pop_front();
        if ({rsp_err, rsp_rdata} !== mon_e)
          begin
            n_err++;
            $display("FAIL rsp_data: got err=%b rdata=%h, required err=%b rdata=%h",
                     rsp_err, rsp_rdata, mon_e.err, mon_e.rdata);
          end
      end
    end
    prev_vld <= rst_n && rsp_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [COLS-1:0] d);
    int t;
    rsp_t e;
    t = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    while (!req_ready && t < 40) begin @(negedge clk); t++; end
    if (t >= 40) begin
      n_cmp++; n_err++;
      $display("FAIL issue_timeout: req_ready=%b, required 1", req_ready);
    end
    e.err = 1'b0;
    if (we) begin e.rdata = '0; shadow[a] = d; end
    else e.rdata = shadow[a];
    exp_q.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = AW'($urandom); req_wdata = COLS'($urandom);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin @(negedge clk); t++; end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: outstanding=%0d, required 0", exp_q.size());
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      req_valid = 1'($urandom); req_we = 1'($urandom); req_addr = AW'($urandom); req_wdata = COLS'($urandom);
      @(negedge clk);
      n_cmp++;
      if ({req_ready, wl, pre_n, sae, bl_drv_en, rsp_valid, rsp_err, rsp_rdata, bl_wdata} !==
          {1'b1, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00}) begin
        n_err++;
        $display("FAIL reset_values: rdy=%b wl=%h pre_n=%b sae=%b drv=%b vld=%b err=%b rd=%h bw=%h, required 1 0000 1 0 0 0 0 00 00",
                 req_ready, wl, pre_n, sae, bl_drv_en, rsp_valid, rsp_err, rsp_rdata, bl_wdata);
      end
    end
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write();
    issue(1'b1, 4'd5, 8'hA5);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      n_cmp++;
      if (pre_n !== (c > 2)) begin
        n_err++; $display("FAIL wr_pre_n c=%0d: got %b, required %b", c, pre_n, (c > 2));
      end
      n_cmp++;
      if (wl !== ((c == 3 || c == 4) ? 16'h0020 : 16'h0000)) begin
        n_err++; $display("FAIL wr_wl c=%0d: got %h", c, wl);
      end
      n_cmp++;
      if (bl_drv_en !== (c == 3 || c == 4) || ((c == 3 || c == 4) && bl_wdata !== 8'hA5)) begin
        n_err++; $display("FAIL wr_drive c=%0d: got drv=%b data=%h, required drv=%b data=a5", c, bl_drv_en, bl_wdata, (c == 3 || c == 4));
      end
      n_cmp++;
      if (rsp_valid !== (c == 5) || req_ready !== (c == 6)) begin
        n_err++; $display("FAIL wr_timing c=%0d: got vld=%b rdy=%b, required vld=%b rdy=%b", c, rsp_valid, req_ready, (c == 5), (c == 6));
      end
    end
    drain();
  endtask

  task automatic test_read();
    issue(1'b0, 4'd5, 8'h00);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      n_cmp++;
      if (sae !== (c == 5) || bl_drv_en !== 1'b0) begin
        n_err++; $display("FAIL rd_sae c=%0d: got sae=%b drv=%b, required sae=%b drv=0", c, sae, bl_drv_en, (c == 5));
      end
      n_cmp++;
      if (wl !== ((c >= 3 && c <= 5) ? 16'h0020 : 16'h0000)) begin
        n_err++; $display("FAIL rd_wl c=%0d: got %h", c, wl);
      end
      n_cmp++;
      if (rsp_valid !== (c == 6) || req_ready !== (c == 7)) begin
        n_err++; $display("FAIL rd_timing c=%0d: got vld=%b rdy=%b, required vld=%b rdy=%b", c, rsp_valid, req_ready, (c == 6), (c == 7));
      end
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int acc, hits, overlap, t;
    rsp_t e;
    issue(1'b1, 4'd15, 8'hC3);
    drain();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd0; req_wdata = 8'h5A;
    t = 0;
    while (!req_ready && t < 40) begin @(negedge clk); t++; end
    e.err = 1'b0; e.rdata = '0; shadow[0] = 8'h5A; exp_q.push_back(e);
    @(posedge clk); #1;
    req_we = 1'b0; req_addr = 4'd15; req_wdata = 8'hFF;
    acc = -1; hits = 0; overlap = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (acc >= 0) req_valid = 1'b0;
      if (wl == 16'h8000) hits++;
      if (wl != '0 && !pre_n) overlap++;
      if (req_ready && req_valid && acc < 0) begin
        acc = c; e.err = 1'b0; e.rdata = shadow[15]; exp_q.push_back(e);
      end
    end
    req_valid = 1'b0;
    n_cmp++;
    if (acc !== 6) begin n_err++; $display("FAIL b2b_accept: got cycle %0d, required 6", acc); end
    n_cmp++;
    if (hits !== 3 || overlap !== 0) begin
      n_err++; $display("FAIL b2b_wl: got wl15 cycles=%0d overlap=%0d, required 3 and 0", hits, overlap);
    end
    drain();
    issue(1'b0, 4'd0, 8'h00);
    drain();
  endtask

  task automatic test_error_rows12();
    int bad, pulses;
    logic [AW-1:0] addrs [2];
    addrs[0] = 4'd13; addrs[1] = 4'd11;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++;
      if (r2_ready !== 1'b1) begin n_err++; $display("FAIL r12_ready: got %b, required 1", r2_ready); end
      r2_valid = 1'b1; r2_we = 1'b0; r2_addr = addrs[k];
      @(posedge clk); #1;
      r2_valid = 1'b0; r2_addr = 4'd2;
      bad = 0; pulses = 0;
      for (int c = 1; c <= 8; c++) begin
        @(negedge clk);
        if (wl2 !== ((k == 1 && c >= 3 && c <= 5) ? 12'h800 : 12'h000)) bad++;
        if (p2_valid) pulses++;
        if (c == 6) begin
          n_cmp++;
          if ({p2_valid, p2_err, p2_rdata} !== ((k == 0) ? {1'b1, 1'b1, 8'h00} : {1'b1, 1'b0, 8'hFF})) begin
            n_err++; $display("FAIL r12_rsp addr=%0d: got vld=%b err=%b rd=%h", addrs[k], p2_valid, p2_err, p2_rdata);
          end
        end
      end
      n_cmp++;
      if (bad !== 0 || pulses !== 1) begin
        n_err++; $display("FAIL r12_wl addr=%0d: got bad wl cycles=%0d pulses=%0d, required 0 and 1", addrs[k], bad, pulses);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [COLS-1:0] old;
    int saw;
    rsp_t e;
    old = shadow[3];
    issue(1'b1, 4'd3, 8'h77);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bl_drv_en !== 1'b1 || wl !== 16'h0008) begin
      n_err++; $display("FAIL mid_pre: got drv=%b wl=%h, required 1 0008", bl_drv_en, wl);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (wl !== 16'h0 || bl_drv_en !== 1'b0 || pre_n !== 1'b1 || req_ready !== 1'b1) begin
      n_err++; $display("FAIL mid_async: got wl=%h drv=%b pre_n=%b rdy=%b, required 0000 0 1 1", wl, bl_drv_en, pre_n, req_ready);
    end
    e = exp_q.pop_back();
    shadow[3] = old;
    saw = 0;
    repeat (4) begin @(negedge clk); if (rsp_valid) saw++; end
    rst_n = 1'b1;
    repeat (3) begin @(negedge clk); if (rsp_valid) saw++; end
    n_cmp++;
    if (saw !== 0) begin n_err++; $display("FAIL mid_norsp: got %0d pulses, required 0", saw); end
    issue(1'b1, 4'd7, 8'h3C);
    issue(1'b0, 4'd7, 8'h00);
    issue(1'b0, 4'd3, 8'h00);
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) issue(1'($urandom), AW'($urandom), COLS'($urandom));
    for (int a = 0; a < ROWS; a += 5) issue(1'b0, AW'(a), 8'h00);
    drain();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_error_rows12();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sram_rw_sequencer.md
Name: sram_rw_sequencer

Overview:
- Timing controller that sits directly upstream of the 6T SRAM bitcell array.
- Accepts single-word read/write requests over a valid/ready handshake.
- Sequences bitline precharge, one-hot wordline assertion, bitline write drive and sense-amp enable for each access.
- Returns read data, or a write acknowledge, as a one-cycle response pulse.

Parameters:
- AW, 4, address width.
- ROWS, 16, number of wordlines; must be ≤ 2**AW.
- COLS, 8, data width (columns per word).
- PRE_CYC, 2, precharge cycles per access; must be ≥ 1.
- ACT_CYC, 2, wordline-active cycles before sense (read) or release (write); must be ≥ 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  AW  row address.
- req_wdata  in  COLS  write data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  COLS  read data; 0 for writes and errors.
- rsp_err  out  1  address ≥ ROWS; valid only with rsp_valid.
- wl  out  ROWS  one-hot wordlines to the array.
- pre_n  out  1  active-low bitline precharge.
- bl_drv_en  out  1  enables column write drivers; complements are generated in the column.
- bl_wdata  out  COLS  data driven onto BL when bl_drv_en = 1.
- sae  out  1  sense-amp enable.
- sa_data  in  COLS  sense-amp outputs; valid during the SENSE cycle.

Behaviour:
- Single clock, asynchronous active-low reset. All outputs are registered.
- Reset values:
  - state = IDLE, req_ready = 1, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0.
  - wl = 0, pre_n = 1, bl_drv_en = 0, bl_wdata = 0, sae = 0.
  - Reset asserted mid-access forces these values immediately, without waiting for a clock edge.
  - The in-flight access is abandoned and no response is produced.
- Handshake:
  - A request is accepted on any edge where req_valid & req_ready.
  - req_we, req_addr and req_wdata are latched at acceptance; later input changes are ignored.
  - req_ready = 1 only in IDLE and drops on the cycle after acceptance.
  - A request held during a busy period stays pending and is accepted the first cycle back in IDLE.
- FSM: IDLE -> PRE -> ACT -> (SENSE if read) -> RECOV -> IDLE. One cycle equals one clock.
  - PRE, PRE_CYC cycles: pre_n = 0, wl = 0, sae = 0, bl_drv_en = 0.
  - ACT, ACT_CYC cycles:
    - pre_n = 1.
    - wl[addr] = 1 if addr < ROWS; otherwise wl = 0 and the error flag is latched.
    - Write: bl_drv_en = 1 and bl_wdata = latched data for all ACT cycles.
  - SENSE, 1 cycle, reads only:
    - wl held, sae = 1.
    - sa_data is sampled at the end of the cycle into rsp_rdata; 0 if the error flag is set.
  - RECOV, 1 cycle:
    - wl = 0, sae = 0, bl_drv_en = 0, pre_n = 1.
    - rsp_valid = 1 and rsp_err = latched error flag.
    - rsp_rdata = 0 for writes and errors.
- Latency, with acceptance edge at cycle 0:
  - Read: rsp_valid at cycle PRE_CYC+ACT_CYC+2; req_ready back at +3.
  - Write: rsp_valid at PRE_CYC+ACT_CYC+1.
  - With defaults: read rsp_valid at cycle 6, write at cycle 5.
  - Back-to-back throughput is one access per PRE_CYC+ACT_CYC+3 cycles (read) or +2 cycles (write).
- rsp_rdata holds its value until the next response. rsp_valid is never held for more than 1 cycle.
- Safety invariants, checked by assertion:
  - $onehot0(wl) at all times.
  - wl != 0 never coincides with pre_n = 0.
  - bl_drv_en implies a write in ACT.
  - sae implies a read in SENSE.
  - sae and bl_drv_en are never both 1.
- Counters are sized clog2(max(PRE_CYC, ACT_CYC)+1). A counter reloads on every state entry and never wraps.

Test Plan:
- Reset: hold rst_n = 0 with random inputs -> req_ready = 1, wl = 0, pre_n = 1, sae = 0, bl_drv_en = 0, rsp_valid = 0.
- Write addr 5, data 0xA5, defaults:
  - pre_n = 0 at cycles 1–2.
  - wl = 0x0020 with bl_drv_en = 1 and bl_wdata = 0xA5 at cycles 3–4.
  - rsp_valid at cycle 5 with rsp_rdata = 0 and rsp_err = 0.
- Read addr 5, model drives sa_data = 0xA5 only while sae:
  - sae at cycle 5 with wl = 0x0020.
  - rsp_valid at cycle 6 with rsp_rdata = 0xA5.
- Back-to-back: req_valid held high for write addr 0 then read addr 15:
  - Second request accepted at cycle 6.
  - Its wl = 0x8000 never overlaps pre_n = 0.
- ROWS = 12, read addr 13 -> wl stays 0 throughout; rsp_valid with rsp_err = 1 and rsp_rdata = 0.
- Assert rst_n = 0 during ACT of a write -> wl and bl_drv_en drop asynchronously; no rsp_valid; next request completes normally.
